irq_timer: RTL and testbench
============================

IRQ_TIMER -- requirements
Module: irq_timer

Interface
REQ-001 Block SHALL have no parameters; all datapaths are fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 addr  input  2  word select (bus addr[3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 we  input  1  write strobe, sampled at clk edge.
REQ-006 din  input  32  write data.
REQ-007 dout  output  32  read data, combinational from addr.
REQ-008 irq  output  1  interrupt request, wired to one bit of the CP0 HWInt[5:0] input.

Function
REQ-009 CTRL layout SHALL be: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM; bits [31:4] SHALL read 0 and ignore writes.
REQ-010 PRESET SHALL be a 32-bit read/write register; COUNT SHALL be read-only, and writes to COUNT or to addr 3 SHALL be ignored.
REQ-011 dout SHALL return CTRL (upper bits 0), PRESET or COUNT per addr, and 0 for addr 3.
REQ-012 FSM states SHALL be IDLE, LOAD, CNT, INT.
REQ-013 IDLE: if EN=1 go to LOAD, else stay; COUNT holds.
REQ-014 LOAD: COUNT <= PRESET; go to CNT.
REQ-015 CNT: if COUNT > 1, COUNT <= COUNT-1 and stay; if COUNT <= 1, COUNT <= 0, set irq_flag, go to INT.
REQ-016 INT, MODE=00: clear CTRL.EN, go to IDLE; irq_flag stays set.
REQ-017 INT, MODE=01: clear irq_flag, go to LOAD, so irq is a one-cycle pulse per period.
REQ-018 EN=0 observed in LOAD, CNT or INT SHALL force IDLE on the next edge; COUNT holds its value; irq_flag is unchanged.
REQ-019 irq SHALL equal irq_flag AND CTRL.IM, combinationally; masking SHALL NOT clear irq_flag.
REQ-020 Any write to CTRL or PRESET SHALL clear irq_flag on that edge, which is the software acknowledge.
REQ-021 A PRESET write while counting SHALL NOT alter COUNT; it takes effect at the next LOAD.
REQ-022 A CTRL write on the same edge as the INT-state EN clear SHALL win, so the written EN value is kept.
REQ-023 An irq_flag set (REQ-015) coinciding with an acknowledge write SHALL leave irq_flag set, so the event is not lost.
REQ-024 PRESET=0 or 1 SHALL reach INT on the first CNT cycle after LOAD.
REQ-025 Latency from the CTRL write edge (EN=1, PRESET=N>=1) to irq assertion SHALL be N+2 clock edges.

Reset
REQ-026 On reset assertion, without waiting for clk: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, irq=0, dout=0 for every addr.
REQ-027 On reset deassertion mid-count, the block SHALL sit in IDLE until software sets EN again.

Verification
REQ-028 Write PRESET=5, then CTRL=0x9 (EN, one-shot, IM) at edge k -> COUNT reads 5,4,3,2,1 on edges k+2..k+6; irq=1 after edge k+7 and stays 1; CTRL reads 0x8 after edge k+8.
REQ-029 Auto-reload, CTRL=0xB, PRESET=3 -> irq is a one-cycle pulse every 5 cycles; COUNT sequence is 3,2,1,0,(LOAD)3,...
REQ-030 One-shot expiry with IM=0 -> irq=0; a later write CTRL=0x8 -> irq stays 0 because the write acknowledged the flag; the same test with a PRESET write instead -> also clears.
REQ-031 EN cleared via CTRL write at COUNT=2 -> IDLE next edge, COUNT holds 2, no irq; EN set again -> LOAD reloads PRESET.
REQ-032 Assert reset asynchronously mid-CNT with irq=1 -> irq, COUNT and CTRL read 0 before the next clk edge.
REQ-033 Write PRESET=0 with EN=1 -> irq asserts 2 edges after the write; a simultaneous INT entry and CTRL write -> irq_flag set and EN per written data.

Source files
------------

// File: rtl/irq_timer.sv
// irq_timer: 32-bit down-counting timer with one-shot / auto-reload modes,
// a three-word register file (CTRL, PRESET, COUNT) and a maskable interrupt.
module irq_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  state_t      state, state_next;
  logic        ctrl_en;
  logic [1:0]  ctrl_mode;
  logic        ctrl_im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic wr_ctrl, wr_preset, auto_reload;
  logic load_count, dec_count, expire, clr_en, clr_flag_reload;

  assign wr_ctrl     = we && (addr == ADDR_CTRL);
  assign wr_preset   = we && (addr == ADDR_PRESET);
  // MODE 1x behaves as one-shot; only 01 reloads.
  assign auto_reload = (ctrl_mode == 2'b01);

  // State register; a reset always parks the timer in IDLE until EN is set again.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a cleared EN outside IDLE wins over every other transition.
  // NOTE: default assignment first so no path through the block leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    if (!ctrl_en) begin
      state_next = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: state_next = S_LOAD;
        S_LOAD: state_next = S_CNT;
        S_CNT:  state_next = (count > 32'd1) ? S_CNT : S_INT;
        S_INT:  state_next = auto_reload ? S_LOAD : S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Per-state datapath strobes, all suppressed when EN is low so COUNT and the flag hold.
  always_comb begin
    load_count      = 1'b0;
    dec_count       = 1'b0;
    expire          = 1'b0;
    clr_en          = 1'b0;
    clr_flag_reload = 1'b0;
    if (ctrl_en) begin
      unique case (state)
        S_LOAD: load_count = 1'b1;
        S_CNT: begin
          dec_count = (count > 32'd1);
          expire    = (count <= 32'd1);
        end
        S_INT: begin
          clr_en          = !auto_reload;
          clr_flag_reload = auto_reload;
        end
        default: ;
      endcase
    end
  end

  // Registers: software writes override the one-shot EN clear, and an expiry
  // beats a simultaneous acknowledge so the event is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'b00;
      ctrl_im   <= 1'b0;
      preset    <= 32'd0;
      count     <= 32'd0;
      irq_flag  <= 1'b0;
    end else begin
      if (wr_ctrl) {ctrl_im, ctrl_mode, ctrl_en} <= din[3:0];
      else if (clr_en) ctrl_en <= 1'b0;

      if (wr_preset) preset <= din;

      if (load_count)     count <= preset;
      else if (dec_count) count <= count - 32'd1;
      else if (expire)    count <= 32'd0;

      if (expire) irq_flag <= 1'b1;
      else if (wr_ctrl || wr_preset || clr_flag_reload) irq_flag <= 1'b0;
    end
  end

  // Read mux; the reserved word reads zero.
  always_comb begin
    dout = 32'd0;
    unique case (addr)
      ADDR_CTRL:   dout = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
      ADDR_PRESET: dout = preset;
      ADDR_COUNT:  dout = count;
      default:     dout = 32'd0;
    endcase
  end

  assign irq = irq_flag & ctrl_im;

endmodule

// File: tb/tb_irq_timer.sv
// tb_irq_timer: directed scenarios plus randomized register traffic, every
// cycle compared against a behavioural timer model kept in the bench.
module tb_irq_timer;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  irq_timer dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Behavioural model: phases named after the timer's lifecycle.
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_CNT = 2, PH_INT = 3;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    bit          flag;
    int          ph;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_zero();
    mdl_t z;
    z.ctrl = 4'd0; z.preset = 32'd0; z.count = 32'd0; z.flag = 1'b0; z.ph = PH_IDLE;
    return z;
  endfunction

  function automatic mdl_t step(input mdl_t s, input logic w, input logic [1:0] a,
                                input logic [31:0] d);
    mdl_t n = s;
    bit hit = 1'b0;
    if (!s.ctrl[0]) n.ph = PH_IDLE;
    else begin
      case (s.ph)
        PH_IDLE: n.ph = PH_LOAD;
        PH_LOAD: begin n.count = s.preset; n.ph = PH_CNT; end
        PH_CNT:
          if (s.count > 32'd1) n.count = s.count - 32'd1;
          else begin n.count = 32'd0; n.flag = 1'b1; hit = 1'b1; n.ph = PH_INT; end
        default:
          if (s.ctrl[2:1] == 2'b01) begin n.flag = 1'b0; n.ph = PH_LOAD; end
          else begin n.ctrl[0] = 1'b0; n.ph = PH_IDLE; end
      endcase
    end
    if (w && a == 2'd0) n.ctrl = d[3:0];
    if (w && a == 2'd1) n.preset = d;
    if (w && a <= 2'd1 && !hit) n.flag = 1'b0;
    return n;
  endfunction

  function automatic logic [31:0] exp_rd(input int a);
    case (a)
      0: return {28'd0, m.ctrl};
      1: return m.preset;
      2: return m.count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = dout;
  endtask

  task automatic verify(input string where);
    logic [31:0] v;
    check({where, ":irq"}, {31'd0, irq}, {31'd0, m.flag & m.ctrl[3]});
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      check($sformatf("%s:rd%0d", where, a), v, exp_rd(a));
    end
    addr = 2'd0;
  endtask

  // One clock edge with optional write; model and DUT advance together.
  task automatic cycle(input logic w, input logic [1:0] a, input logic [31:0] d);
    mdl_t nxt;
    we = w; addr = a; din = d;
    nxt = step(m, w, a, d);
    @(posedge clk);
    m = nxt;
    #1;
    we = 1'b0; din = 32'd0;
    verify("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 32'd0);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic pulse_reset(input string where);
    reset = 1'b1;
    m = mdl_zero();
    #1;
    verify(where);
    @(posedge clk);
    #1;
    reset = 1'b0;
    verify({where, "_rel"});
  endtask

  logic [31:0] v;
  int          pulses, doubles, first_at;
  logic        prev;

  initial begin
    reset = 1'b0; we = 1'b0; addr = 2'd0; din = 32'd0;
    m = mdl_zero();
    #1 reset = 1'b1;
    #1 verify("por");
    @(posedge clk);
    #1 reset = 1'b0;
    verify("por_rel");

    // One-shot, PRESET=5, CTRL=0x9 written at edge k.
    cycle(1'b1, 2'd1, 32'd5);
    cycle(1'b1, 2'd0, 32'h9);
    for (int i = 1; i <= 8; i++) begin
      idle(1);
      if (i >= 2 && i <= 6) begin
        rd(2'd2, v); check($sformatf("os_count_k%0d", i), v, 32'(7 - i));
      end
      if (i <= 6) check($sformatf("os_noirq_k%0d", i), {31'd0, irq}, 32'd0);
      if (i >= 7) check($sformatf("os_irq_k%0d", i), {31'd0, irq}, 32'd1);
      if (i == 8) begin rd(2'd0, v); check("os_ctrl_en_clr", v, 32'h8); end
    end
    idle(3);
    check("os_irq_sticky", {31'd0, irq}, 32'd1);
    cycle(1'b1, 2'd0, 32'h0);
    check("os_ack", {31'd0, irq}, 32'd0);

    // Auto-reload, PRESET=3: a one-cycle pulse every 5 cycles.
    cycle(1'b1, 2'd1, 32'd3);
    cycle(1'b1, 2'd0, 32'hB);
    pulses = 0; doubles = 0; first_at = 0; prev = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      idle(1);
      if (irq) begin
        pulses++;
        if (first_at == 0) first_at = i;
      end
      if (irq && prev) doubles++;
      prev = irq;
    end
    check("ar_pulses", 32'(pulses), 32'd4);
    check("ar_first", 32'(first_at), 32'd5);
    check("ar_width", 32'(doubles), 32'd0);
    cycle(1'b1, 2'd0, 32'h0);
    idle(2);

    // Masked expiry, then acknowledge by CTRL write and by PRESET write.
    cycle(1'b1, 2'd1, 32'd2);
    cycle(1'b1, 2'd0, 32'h1);
    idle(6);
    check("mask_noirq", {31'd0, irq}, 32'd0);
    cycle(1'b1, 2'd0, 32'h8);
    check("mask_ctrl_ack", {31'd0, irq}, 32'd0);
    cycle(1'b1, 2'd0, 32'h9);
    idle(6);
    check("pre_ack_setup", {31'd0, irq}, 32'd1);
    cycle(1'b1, 2'd1, 32'd4);
    check("pre_ack", {31'd0, irq}, 32'd0);
    cycle(1'b1, 2'd0, 32'h0);

    // EN cleared at COUNT=2, then re-enabled.
    cycle(1'b1, 2'd1, 32'd6);
    cycle(1'b1, 2'd0, 32'h9);
    idle(5);
    cycle(1'b1, 2'd0, 32'h8);
    idle(3);
    rd(2'd2, v); check("dis_hold", v, 32'd2);
    check("dis_noirq", {31'd0, irq}, 32'd0);
    cycle(1'b1, 2'd0, 32'h9);
    idle(2);
    rd(2'd2, v); check("reen_reload", v, 32'd6);
    cycle(1'b1, 2'd0, 32'h0);

    // PRESET=0 written just before LOAD; then collisions at INT entry and INT exit.
    cycle(1'b1, 2'd1, 32'd7);
    cycle(1'b1, 2'd0, 32'h9);
    cycle(1'b1, 2'd1, 32'd0);
    idle(1);
    check("p0_early", {31'd0, irq}, 32'd0);
    cycle(1'b1, 2'd0, 32'h9);
    check("p0_irq_kept", {31'd0, irq}, 32'd1);
    cycle(1'b1, 2'd0, 32'h9);
    rd(2'd0, v); check("int_wr_wins", v, 32'h9);
    cycle(1'b1, 2'd0, 32'h0);
    idle(2);

    // Async reset while irq is high, then stay idle after release.
    cycle(1'b1, 2'd1, 32'd3);
    cycle(1'b1, 2'd0, 32'hB);
    idle(5);
    check("rst_pre_irq", {31'd0, irq}, 32'd1);
    pulse_reset("rst_irq");
    idle(5);
    rd(2'd2, v); check("rst_idle_count", v, 32'd0);

    // Async reset mid-count.
    cycle(1'b1, 2'd1, 32'd9);
    cycle(1'b1, 2'd0, 32'h9);
    idle(4);
    pulse_reset("rst_cnt");
    idle(3);

    // Randomized register traffic.
    for (int i = 0; i < 600; i++) begin
      logic [1:0]  a;
      logic [31:0] d;
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset("rnd_rst");
      end else if ($urandom_range(0, 9) < 2) begin
        a = 2'($urandom_range(0, 3));
        d = $urandom();
        if (a == 2'd0) d[0] = ($urandom_range(0, 3) != 0);
        if (a == 2'd1) d = 32'($urandom_range(0, 7));
        cycle(1'b1, a, d);
      end else begin
        cycle(1'b0, 2'($urandom_range(0, 3)), $urandom());
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
